// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared flex_counter: latches the winner's delay length, clears,
// runs the count until rollover, then pulses done to the owner.
module counter_arbiter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    req_a,
  input  logic [NUM_CNT_BITS-1:0] len_a,
  input  logic                    req_b,
  input  logic [NUM_CNT_BITS-1:0] len_b,
  output logic                    grant_a,
  output logic                    grant_b,
  output logic                    done_a,
  output logic                    done_b,
  output logic                    busy,
  output logic                    cnt_clear,
  output logic                    cnt_enable,
  output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
  input  logic                    cnt_rollover_flag
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  // Requester encoding for owner/last_grant: 0 = A, 1 = B.
  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_q, last_d;
  logic [NUM_CNT_BITS-1:0] len_q, len_d;

  logic                    winner;
  logic [NUM_CNT_BITS-1:0] winner_len;
  logic                    owner_req;

  // On a tie the requester not served last time wins.
  assign winner     = (req_a & req_b) ? ~last_q : req_b;
  assign winner_len = winner ? len_b : len_a;
  assign owner_req  = owner_q ? req_b : req_a;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (req_a | req_b) begin
          state_d = StLoad;
          owner_d = winner;
          last_d  = winner;
          len_d   = (winner_len == '0) ? NUM_CNT_BITS'(1) : winner_len;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        // A withdrawn request abandons the count; the next LOAD clears the counter.
        if (!owner_req) begin
          state_d = StIdle;
        end else if (cnt_rollover_flag) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= NUM_CNT_BITS'(1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      len_q   <= len_d;
    end
  end

  // Every output is a decode of registered state only.
  assign busy             = (state_q != StIdle);
  assign grant_a          = busy & ~owner_q;
  assign grant_b          = busy & owner_q;
  assign done_a           = (state_q == StDone) & ~owner_q;
  assign done_b           = (state_q == StDone) & owner_q;
  assign cnt_clear        = (state_q == StLoad) | (state_q == StDone);
  assign cnt_enable       = (state_q == StRun);
  assign cnt_rollover_val = len_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: flex_counter stand-in, timeline reference model, directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_counter_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] len_a = '0, len_b = '0;
  logic         grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable;
  logic [W-1:0] cnt_rollover_val;
  logic         cnt_rollover_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_arbiter #(.NUM_CNT_BITS(W)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .req_a            (req_a),
    .len_a            (len_a),
    .req_b            (req_b),
    .len_b            (len_b),
    .grant_a          (grant_a),
    .grant_b          (grant_b),
    .done_a           (done_a),
    .done_b           (done_b),
    .busy             (busy),
    .cnt_clear        (cnt_clear),
    .cnt_enable       (cnt_enable),
    .cnt_rollover_val (cnt_rollover_val),
    .cnt_rollover_flag(cnt_rollover_flag)
  );

  // Conforming flex_counter: flag is high while count equals rollover_val.
  logic [W-1:0] fc_count;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fc_count <= '0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_clear) begin
      fc_count <= '0;
      cnt_rollover_flag <= 1'b0;
    end else if (cnt_enable) begin
      if (fc_count == cnt_rollover_val) begin
        fc_count <= W'(1);
        cnt_rollover_flag <= (cnt_rollover_val == W'(1));
      end else begin
        fc_count <= fc_count + 1'b1;
        cnt_rollover_flag <= ((fc_count + 1'b1) == cnt_rollover_val);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic winner_of(input logic ra, input logic rb, input logic last);
    return (ra && rb) ? !last : rb;
  endfunction

  function automatic int eff_len(input logic [W-1:0] l);
    return (l == '0) ? 1 : int'(l);
  endfunction

  // Reference: a transaction is a timeline t=1 (load) .. L+3 (done) owned by one requester.
  logic m_active, m_owner, m_last;
  int   m_len, m_t;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active <= 1'b0;
      m_owner  <= 1'b0;
      m_last   <= 1'b1;
      m_len    <= 1;
      m_t      <= 0;
    end else if (!m_active) begin
      if (req_a || req_b) begin
        m_active <= 1'b1;
        m_owner  <= winner_of(req_a, req_b, m_last);
        m_last   <= winner_of(req_a, req_b, m_last);
        m_len    <= winner_of(req_a, req_b, m_last) ? eff_len(len_b) : eff_len(len_a);
        m_t      <= 1;
      end
    end else if (m_t >= 2 && m_t <= m_len + 2 && !(m_owner ? req_b : req_a)) begin
      m_active <= 1'b0;
    end else if (m_t == m_len + 3) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  logic e_done, e_clear, e_en;
  always_comb begin
    e_done  = m_active && (m_t == m_len + 3);
    e_clear = m_active && (m_t == 1 || m_t == m_len + 3);
    e_en    = m_active && (m_t >= 2) && (m_t <= m_len + 2);
  end

  always @(negedge clk) begin
    check("cycle_outputs",
          {21'd0, grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable, cnt_rollover_val},
          {21'd0, m_active && !m_owner, m_active && m_owner, e_done && !m_owner, e_done && m_owner,
           m_active, e_clear, e_en, W'(m_len)});
    check("grant_exclusive", {31'd0, grant_a & grant_b}, 32'd0);
  end

  // One request from A (b=0) or B (b=1), dropped on the edge after its done.
  task automatic directed(input logic b, input logic [W-1:0] len, output logic [23:0] en,
                          output logic [23:0] cl, output logic [23:0] dn,
                          output logic gother, output logic [W-1:0] rv);
    en = '0; cl = '0; dn = '0; gother = 1'b0; rv = '0;
    @(posedge clk); #1;
    if (b) begin req_b = 1'b1; len_b = len; end
    else   begin req_a = 1'b1; len_a = len; end
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk); #1;
      if (c > 1 && dn[c-2]) begin req_a = 1'b0; req_b = 1'b0; end
      @(negedge clk);
      en[c-1] = cnt_enable;
      cl[c-1] = cnt_clear;
      dn[c-1] = b ? done_b : done_a;
      gother  = gother | (b ? grant_a : grant_b);
      if (c == 2) rv = cnt_rollover_val;
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  logic [23:0] v_en, v_cl, v_dn;
  logic        v_go;
  logic [W-1:0] v_rv;
  logic [5:0]  ab_busy, ab_gb, ab_cl;
  logic        ab_da;
  int          nloads;
  int          loads [4];
  logic        da, db;

  initial begin
    // Reset with requests toggling: everything held at reset values.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_a = ~req_a; req_b = (i % 2 == 0); len_a = W'(i + 3);
    end
    @(negedge clk);
    check("reset_outputs",
          {21'd0, grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable, cnt_rollover_val},
          32'h1);
    req_a = 1'b0; req_b = 1'b0;
    #1 n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset_busy", {31'd0, busy}, 32'd0);

    directed(1'b0, W'(2), v_en, v_cl, v_dn, v_go, v_rv);
    check("a2_enable", {8'd0, v_en}, 32'h0000_000E);
    check("a2_clear", {8'd0, v_cl}, 32'h0000_0011);
    check("a2_done", {8'd0, v_dn}, 32'h0000_0010);
    check("a2_grant_b", {31'd0, v_go}, 32'd0);
    check("a2_rollover", {28'd0, v_rv}, 32'd2);

    directed(1'b1, W'(0), v_en, v_cl, v_dn, v_go, v_rv);
    check("b0_enable", {8'd0, v_en}, 32'h0000_0006);
    check("b0_done", {8'd0, v_dn}, 32'h0000_0008);
    check("b0_rollover", {28'd0, v_rv}, 32'd1);

    directed(1'b0, W'(15), v_en, v_cl, v_dn, v_go, v_rv);
    check("a15_enable", {8'd0, v_en}, 32'h0001_FFFE);
    check("a15_clear", {8'd0, v_cl}, 32'h0002_0001);
    check("a15_done", {8'd0, v_dn}, 32'h0002_0000);
    check("a15_rollover", {28'd0, v_rv}, 32'd15);

    // Tie from reset: A(3) first, then strict alternation; loads at cycles 1, 8, 17, 24.
    @(posedge clk); #1;
    n_rst = 1'b0; req_a = 1'b1; req_b = 1'b1; len_a = W'(3); len_b = W'(5);
    @(negedge clk); #1 n_rst = 1'b1;
    nloads = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); @(negedge clk);
      if (busy && cnt_clear && !done_a && !done_b && nloads < 4) begin
        loads[nloads] = c * 2 + int'(grant_b);
        nloads++;
      end
      if (c == 9) check("tie_b_rollover", {28'd0, cnt_rollover_val}, 32'd5);
    end
    check("tie_load0", loads[0], 32'd2);
    check("tie_load1", loads[1], 32'd17);
    check("tie_load2", loads[2], 32'd34);
    check("tie_load3", loads[3], 32'd49);
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;
    repeat (25) @(posedge clk);

    // Abort: A drops in its 2nd run cycle; pending B is then loaded.
    #1 req_a = 1'b1; len_a = W'(5);
    ab_da = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin req_b = 1'b1; len_b = W'(2); end
      if (c == 3) req_a = 1'b0;
      @(negedge clk);
      ab_busy[c-1] = busy; ab_gb[c-1] = grant_b; ab_cl[c-1] = cnt_clear;
      ab_da = ab_da | done_a;
    end
    check("abort_busy", {26'd0, ab_busy}, 32'h37);
    check("abort_grant_b", {26'd0, ab_gb}, 32'h30);
    check("abort_clear", {26'd0, ab_cl}, 32'h11);
    check("abort_no_done_a", {31'd0, ab_da}, 32'd0);

    // Reset while B runs: outputs drop at once, then a tie goes to A.
    @(posedge clk); #1 n_rst = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {21'd0, grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable, cnt_rollover_val},
          32'h1);
    req_a = 1'b1; len_a = W'(4);
    @(negedge clk); #1 n_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_reset_tie_a", {29'd0, grant_a, grant_b, cnt_clear}, 32'h5);
    @(posedge clk); #1 req_a = 1'b0; req_b = 1'b0;
    repeat (10) @(posedge clk);

    // Randomized traffic, occasional aborts, length changes and resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      da = done_a; db = done_b;
      @(posedge clk); #1;
      if (req_a && da) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 3) == 0) begin req_a = 1'b1; len_a = W'($urandom); end
      else if (req_a && m_active && !m_owner && m_t <= m_len + 1 && $urandom_range(0, 19) == 0)
        req_a = 1'b0;
      if (req_b && db) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 3) == 0) begin req_b = 1'b1; len_b = W'($urandom); end
      else if (req_b && m_active && m_owner && m_t <= m_len + 1 && $urandom_range(0, 19) == 0)
        req_b = 1'b0;
      if ($urandom_range(0, 7) == 0) len_a = W'($urandom);
      if ($urandom_range(0, 7) == 0) len_b = W'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        n_rst = 1'b0;
        #1;
        check("rand_reset_outputs",
              {21'd0, grant_a, grant_b, done_a, done_b, busy, cnt_clear, cnt_enable,
               cnt_rollover_val}, 32'h1);
        @(negedge clk); #1 n_rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
